// File: rtl/seq_sched_pkg.sv
// Shared types, defaults and the round-robin pick helper for the
// serial pattern-match scheduler.
package seq_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    // Default word and pattern geometry
    localparam int         DEF_WORD_W  = 8;
    localparam int         DEF_PAT_W   = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b0110;

    // Widest request vector the pick helper handles
    localparam int RR_MAX = 32;

    // First set request at or after ptr, wrapping at nreq.
    // Returns ptr when nothing is set (callers only use it with req!=0).
    function automatic int rr_pick(
        input logic [RR_MAX-1:0] req,
        input int                ptr,
        input int                nreq
    );
        int   pick;
        int   idx;
        logic found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            if (k < nreq) begin
                idx = ptr + k;
                if (idx >= nreq) begin
                    idx = idx - nreq;
                end else begin
                    idx = idx;
                end
                if (!found && req[idx]) begin
                    pick  = idx;
                    found = 1'b1;
                end else begin
                    found = found;
                end
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: a (PAT_W-1)-bit history plus a fill counter, so
// a match is only reported once a full window of the current word is seen.
module seq_match_core #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b0110
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_vld,
    input  logic bit_in,
    output logic match
);

    localparam int               FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist_r;
    logic [FILL_W-1:0] fill_r;
    logic              match_r;
    logic [PAT_W-1:0]  win_s;

    // Current window: history followed by the incoming bit (oldest first)
    always_comb begin
        win_s = {hist_r, bit_in};
    end

    // History shift, fill tracking and registered match flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_r  <= {(PAT_W-1){1'b0}};
            fill_r  <= {FILL_W{1'b0}};
            match_r <= 1'b0;
        end else if (clr) begin
            hist_r  <= {(PAT_W-1){1'b0}};
            fill_r  <= {FILL_W{1'b0}};
            match_r <= 1'b0;
        end else if (bit_vld) begin
            match_r <= (fill_r == FILL_FULL) && (win_s == PATTERN);
            hist_r  <= win_s[PAT_W-2:0];
            if (fill_r != FILL_FULL) begin
                fill_r <= fill_r + FILL_W'(1'b1);
            end
        end else begin
            match_r <= 1'b0;
        end
    end

    assign match = match_r;

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one serial pattern matcher between NREQ
// requesters. Each granted word is shifted MSB-first, hits are counted and
// the count is reported with the requester id on a one-cycle done pulse.
module seq_detect_scheduler
    import seq_sched_pkg::*;
#(
    parameter int               NREQ    = 4,
    parameter int               WORD_W  = DEF_WORD_W,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    localparam int              IDW     = $clog2(NREQ),
    localparam int              CNT_W   = $clog2(WORD_W + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WORD_W-1:0] req_word,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic                   bit_out,
    output logic                   done,
    output logic [IDW-1:0]         done_id,
    output logic [CNT_W-1:0]       hit_cnt
);

    localparam int IDX_W = $clog2(WORD_W);

    state_t              state_r;
    logic [WORD_W-1:0]   word_r;
    logic [IDW-1:0]      id_r;
    logic [IDW-1:0]      ptr_r;
    logic [IDX_W-1:0]    idx_r;
    logic [CNT_W-1:0]    cnt_r;

    logic [NREQ-1:0]     gnt_r;
    logic                busy_r;
    logic                bit_out_r;
    logic                done_r;
    logic [IDW-1:0]      done_id_r;
    logic [CNT_W-1:0]    hit_cnt_r;

    logic [RR_MAX-1:0]   req_ext_s;
    logic [IDW-1:0]      win_s;
    logic [WORD_W-1:0]   win_word_s;
    logic                any_req_s;
    logic                clr_s;
    logic                bit_vld_s;
    logic                match_s;

    // Round-robin winner among current requests and the word it carries
    always_comb begin
        req_ext_s            = {RR_MAX{1'b0}};
        req_ext_s[NREQ-1:0]  = req;
        win_s                = IDW'(rr_pick(req_ext_s, int'(ptr_r), NREQ));
        win_word_s           = req_word[win_s*WORD_W +: WORD_W];
        any_req_s            = |req;
    end

    // Engine control: wipe history on grant, feed bits only while shifting
    always_comb begin
        clr_s     = (state_r == IDLE) && any_req_s;
        bit_vld_s = (state_r == SHIFT);
    end

    seq_match_core #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_s),
        .bit_vld (bit_vld_s),
        .bit_in  (bit_out_r),
        .match   (match_s)
    );

    // Scheduler FSM: arbitration, word shifting, hit counting, result report
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            word_r    <= {WORD_W{1'b0}};
            id_r      <= {IDW{1'b0}};
            ptr_r     <= {IDW{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            gnt_r     <= {NREQ{1'b0}};
            busy_r    <= 1'b0;
            bit_out_r <= 1'b0;
            done_r    <= 1'b0;
            done_id_r <= {IDW{1'b0}};
            hit_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r    <= 1'b0;
                    done_id_r <= {IDW{1'b0}};
                    hit_cnt_r <= {CNT_W{1'b0}};
                    if (any_req_s) begin
                        state_r   <= SHIFT;
                        word_r    <= win_word_s;
                        id_r      <= win_s;
                        idx_r     <= IDX_W'(WORD_W - 1);
                        cnt_r     <= {CNT_W{1'b0}};
                        gnt_r     <= NREQ'(1'b1) << win_s;
                        busy_r    <= 1'b1;
                        // The MSB must be on the engine input in the first SHIFT cycle
                        bit_out_r <= win_word_s[WORD_W-1];
                        if (win_s == IDW'(NREQ - 1)) begin
                            ptr_r <= {IDW{1'b0}};
                        end else begin
                            ptr_r <= win_s + IDW'(1'b1);
                        end
                    end else begin
                        gnt_r     <= {NREQ{1'b0}};
                        busy_r    <= 1'b0;
                        bit_out_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    gnt_r  <= {NREQ{1'b0}};
                    word_r <= {word_r[WORD_W-2:0], 1'b0};
                    if (match_s) begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                    if (idx_r == {IDX_W{1'b0}}) begin
                        state_r   <= DRAIN;
                        bit_out_r <= 1'b0;
                    end else begin
                        idx_r     <= idx_r - IDX_W'(1'b1);
                        bit_out_r <= word_r[WORD_W-2];
                    end
                end
                DRAIN: begin
                    // The match from the last shifted bit lands in this cycle
                    hit_cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, match_s};
                    done_r    <= 1'b1;
                    done_id_r <= id_r;
                    state_r   <= REPORT;
                end
                REPORT: begin
                    done_r    <= 1'b0;
                    done_id_r <= {IDW{1'b0}};
                    hit_cnt_r <= {CNT_W{1'b0}};
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    gnt_r     <= {NREQ{1'b0}};
                    busy_r    <= 1'b0;
                    bit_out_r <= 1'b0;
                    done_r    <= 1'b0;
                    done_id_r <= {IDW{1'b0}};
                    hit_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign gnt     = gnt_r;
    assign busy    = busy_r;
    assign bit_out = bit_out_r;
    assign done    = done_r;
    assign done_id = done_id_r;
    assign hit_cnt = hit_cnt_r;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboard bench for seq_detect_scheduler: a reference model predicts
// grants and results from the request stream; a monitor compares them.
module tb_seq_detect_scheduler;

    localparam int               NREQ    = 4;
    localparam int               WORD_W  = 8;
    localparam int               PAT_W   = 4;
    localparam logic [PAT_W-1:0] PATTERN = 4'b0110;
    localparam int               IDW     = 2;
    localparam int               CNT_W   = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*WORD_W-1:0] req_word;
    logic [WORD_W-1:0]      word_a [NREQ];
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   bit_out;
    logic                   done;
    logic [IDW-1:0]         done_id;
    logic [CNT_W-1:0]       hit_cnt;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) req_word[i*WORD_W +: WORD_W] = word_a[i];
    end

    seq_detect_scheduler #(
        .NREQ(NREQ), .WORD_W(WORD_W), .PAT_W(PAT_W), .PATTERN(PATTERN)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_word(req_word),
        .gnt(gnt), .busy(busy), .bit_out(bit_out), .done(done),
        .done_id(done_id), .hit_cnt(hit_cnt)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int cyc; int val; } gexp_t;
    typedef struct { int cyc; int id; int hits; } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];

    int                ptr_m   = 0;
    int                free_at = 0;
    int                arb_t   = 0;
    int                win_m   = 0;
    logic              active_m = 1'b0;
    logic [WORD_W-1:0] cur_word_m = '0;

    function automatic int ref_hits(input logic [WORD_W-1:0] w);
        int h;
        logic [PAT_W-1:0] win;
        h = 0;
        for (int s = 0; s <= WORD_W - PAT_W; s++) begin
            win = w[WORD_W-1-s -: PAT_W];
            if (win == PATTERN) h++;
        end
        return h;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            gq.delete();
            rq.delete();
            ptr_m    = 0;
            free_at  = 0;
            active_m = 1'b0;
        end else if (cyc >= free_at && req != '0) begin
            win_m = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (win_m < 0 && req[(ptr_m + k) % NREQ]) win_m = (ptr_m + k) % NREQ;
            end
            cur_word_m = word_a[win_m];
            gq.push_back('{cyc + 1, 1 << win_m});
            rq.push_back('{cyc + WORD_W + 2, win_m, ref_hits(cur_word_m)});
            arb_t    = cyc;
            active_m = 1'b1;
            free_at  = cyc + WORD_W + 3;
            ptr_m    = (win_m + 1) % NREQ;
        end
        cyc++;
    end

    // ---------------- monitor ----------------
    gexp_t mon_g;
    rexp_t mon_r;
    int    exp_busy;
    int    exp_bit;

    always @(negedge clk) begin
        if (rst) begin
            exp_busy = (active_m && cyc >= arb_t + 1 && cyc <= arb_t + WORD_W + 2) ? 1 : 0;
            chk("busy", int'(busy), exp_busy);
            exp_bit = (active_m && cyc >= arb_t + 1 && cyc <= arb_t + WORD_W)
                      ? int'(cur_word_m[WORD_W - (cyc - arb_t)]) : 0;
            chk("bit_out", int'(bit_out), exp_bit);
            if (gq.size() > 0 && gq[0].cyc < cyc) begin
                mon_g = gq.pop_front();
                chk("gnt_missing", 0, mon_g.val);
            end
            if (gnt != '0) begin
                if (gq.size() == 0) chk("gnt_unexpected", int'(gnt), 0);
                else begin
                    mon_g = gq.pop_front();
                    chk("gnt_cycle", cyc, mon_g.cyc);
                    chk("gnt_value", int'(gnt), mon_g.val);
                end
            end
            if (rq.size() > 0 && rq[0].cyc < cyc) begin
                mon_r = rq.pop_front();
                chk("done_missing", 0, 1);
            end
            if (done) begin
                if (rq.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    mon_r = rq.pop_front();
                    chk("done_cycle", cyc, mon_r.cyc);
                    chk("done_id", int'(done_id), mon_r.id);
                    chk("hit_cnt", int'(hit_cnt), mon_r.hits);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) req[i] = 1'b0;
    endtask

    task automatic run_one(input int id, input logic [WORD_W-1:0] w, input int exp_hit);
        int n;
        logic got;
        n = 0;
        got = 1'b0;
        word_a[id] = w;
        req[id] = 1'b1;
        while (!got && n < 40) begin
            tick();
            n++;
            if (n == 1) chk("dir_gnt", int'(gnt), 1 << id);
            if (done) begin
                got = 1'b1;
                chk("dir_latency", n, WORD_W + 2);
                chk("dir_done_id", int'(done_id), id);
                chk("dir_hit_cnt", int'(hit_cnt), exp_hit);
            end
        end
        if (!got) chk("dir_done_timeout", 0, 1);
        tick();
    endtask

    task automatic run_multi(input logic [NREQ-1:0] mask, input logic [WORD_W-1:0] w,
                             input int o0, input int o1, input int o2, input int o3,
                             input int cnt, input int exp_hit);
        int order[$];
        int exp_o[4];
        int n, ndone, last_done;
        exp_o[0] = o0; exp_o[1] = o1; exp_o[2] = o2; exp_o[3] = o3;
        n = 0; ndone = 0; last_done = -1;
        for (int i = 0; i < NREQ; i++) if (mask[i]) word_a[i] = w;
        req = req | mask;
        while (ndone < cnt && n < 200) begin
            tick();
            n++;
            for (int i = 0; i < NREQ; i++) if (gnt[i]) order.push_back(i);
            if (done) begin
                chk("multi_hit_cnt", int'(hit_cnt), exp_hit);
                if (last_done >= 0) chk("done_spacing", n - last_done, WORD_W + 3);
                last_done = n;
                ndone++;
            end
        end
        if (ndone < cnt) chk("multi_done_timeout", ndone, cnt);
        chk("grant_count", order.size(), cnt);
        for (int k = 0; k < cnt; k++) begin
            if (k < order.size()) chk("grant_order", order[k], exp_o[k]);
        end
        tick();
    endtask

    initial begin
        int n;
        logic [WORD_W-1:0] w;
        for (int i = 0; i < NREQ; i++) word_a[i] = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bit_out", int'(bit_out), 0);
        chk("rst_done_id", int'(done_id), 0);
        chk("rst_hit_cnt", int'(hit_cnt), 0);
        rst = 1'b1;
        tick();

        // All four at once from pointer 0
        run_multi(4'b1111, 8'b00000000, 0, 1, 2, 3, 4, 0);
        run_one(0, 8'b01100110, 2);
        run_one(2, 8'b01101101, 2);
        run_one(1, 8'b00000011, 0);
        run_one(1, 8'b01111111, 0);
        // Pointer sits after 1: requester 0 goes first
        run_multi(4'b0011, 8'b01100110, 0, 1, 0, 0, 2, 2);

        // Reset in the 4th SHIFT cycle
        word_a[2] = 8'b01111111;
        req[2] = 1'b1;
        tick();
        chk("rs_gnt", int'(gnt), 4);
        repeat (3) tick();
        chk("rs_pre_busy", int'(busy), 1);
        chk("rs_pre_bit_out", int'(bit_out), 1);
        #1 rst = 1'b0;
        #1;
        chk("rs_gnt0", int'(gnt), 0);
        chk("rs_busy0", int'(busy), 0);
        chk("rs_done0", int'(done), 0);
        chk("rs_bit_out0", int'(bit_out), 0);
        chk("rs_done_id0", int'(done_id), 0);
        chk("rs_hit_cnt0", int'(hit_cnt), 0);
        tick();
        tick();
        rst = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) n++;
        end
        chk("rs_no_done", n, 0);
        run_one(3, 8'b01100000, 1);

        // Randomized traffic
        for (int it = 0; it < 600; it++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(3, 0) == 0) begin
                    w = WORD_W'($urandom);
                    if ($urandom_range(1, 0) == 1) w[$urandom_range(WORD_W - PAT_W, 0) +: PAT_W] = PATTERN;
                    word_a[i] = w;
                    req[i] = 1'b1;
                end
            end
        end
        n = 0;
        while ((req != '0 || rq.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        if (req != '0 || rq.size() != 0) chk("drain_timeout", 0, 1);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
Shares one serial pattern-match engine between NREQ requesters. Each requester submits a WORD_W-bit word. A round-robin arbiter grants one requester at a time, and the word is shifted MSB-first into the engine one bit per clock. The block counts pattern hits in that word and reports the count and the requester id with a done pulse.

Parameters:
NREQ, 4, number of requesters (>=2)
WORD_W, 8, bits per submitted word
PAT_W, 4, pattern length (2 <= PAT_W <= WORD_W)
PATTERN, 4'b0110, pattern to detect; MSB is the first bit in time
IDW (localparam), $clog2(NREQ), requester id width
CNT_W (localparam), $clog2(WORD_W+1), hit counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous assert, active-low
req  input  NREQ  per-requester request; hold high until gnt is seen
req_word  input  NREQ*WORD_W  word for requester i at bits [i*WORD_W +: WORD_W]
gnt  output  NREQ  one-hot, single-cycle acceptance pulse
busy  output  1  high in any state other than IDLE
bit_out  output  1  bit currently fed to the engine (debug)
done  output  1  single-cycle result-valid pulse
done_id  output  IDW  id of the finished requester; valid while done=1
hit_cnt  output  CNT_W  pattern hits in the word; valid while done=1

Behaviour:
- Reset (rst=0):
  - State goes to IDLE.
  - gnt, busy, done, bit_out, done_id and hit_cnt all go to 0.
  - Round-robin pointer resets so requester 0 has top priority.
  - Engine history is cleared.
  - Reset mid-operation abandons the word: no done pulse, and the requester is not re-served unless it requests again.
- FSM states: IDLE, SHIFT, DRAIN, REPORT.
- IDLE with req!=0:
  - Pick the first set req at or after the pointer, with wrap-around.
  - Latch that word and id.
  - Register gnt for the winner.
  - Clear engine history, set bit index to WORD_W-1, go to SHIFT.
  - gnt is high for exactly the first SHIFT cycle.
  - Pointer becomes winner+1 mod NREQ.
- IDLE with req==0: stay in IDLE; outputs stay 0.
- SHIFT:
  - Each cycle, feed word[idx] to the engine with bit_vld=1, then decrement idx.
  - After the idx=0 bit, go to DRAIN.
  - SHIFT lasts exactly WORD_W cycles.
- DRAIN: one cycle, bit_vld=0, so the last registered match can be counted.
- hit counter:
  - Cleared on grant.
  - Increments in every SHIFT or DRAIN cycle where engine match=1.
  - Cannot overflow, since the maximum is WORD_W-PAT_W+1.
- REPORT: done=1, done_id and hit_cnt driven, then go to IDLE.
- Latency: arbitration in cycle T, gnt at T+1, done at T+WORD_W+2. Back-to-back words therefore have a period of WORD_W+3 cycles.
- Requests are ignored while busy. Any req still high on return to IDLE is arbitrated normally.
- A requester that holds req past its gnt cycle is served again only in its next round-robin turn.
- Simultaneous requests are granted strictly round-robin; no requester starves.
- Engine (seq_match_core):
  - Keeps a (PAT_W-1)-bit history shift register and a fill counter.
  - On bit_vld: when the fill count is at least PAT_W-1 and {hist, bit_in}==PATTERN, match is set to 1 in the next cycle; otherwise match is 0.
  - Overlapping matches are counted.
  - Synchronous clr empties history and fill, so there are no cross-word matches.
- bit_out equals the engine input during SHIFT and is 0 otherwise.

Decomposition:
- Package seq_sched_pkg holds:
  - the state enum typedef (IDLE, SHIFT, DRAIN, REPORT);
  - default constants for PATTERN, PAT_W and WORD_W;
  - a function for the next round-robin winner.
- Sub-module seq_match_core:
  - ports: clk, rst, clr, bit_vld, bit_in, match;
  - parameters: PAT_W, PATTERN.
- The top level contains the arbiter, the word shift register, the FSM and the hit counter.

Test Plan:
- Single request, req[0]=1, word 8'b01100110 → gnt=4'b0001 one cycle after arbitration; done 10 cycles after arbitration with done_id=0 and hit_cnt=2.
- Overlap, word 8'b01101101 on req[2] → hit_cnt=2 (the two matches share a 0); done_id=2.
- No cross-word hits: req[1] with 8'b00000011, then 8'b01111111 → both report hit_cnt=0.
- All four requesters request with word 8'b00000000 and keep req high until gnt → grants in order 0,1,2,3; done pulses spaced exactly 11 cycles apart; every hit_cnt=0.
- Pointer fairness: after a grant to 1, req=4'b0011 → grant goes to 0 next, not to 1.
- Reset mid-SHIFT: assert rst low at the 4th SHIFT cycle → all outputs 0 asynchronously and no done pulse. After release, req[3] with 8'b01100000 → done_id=3, hit_cnt=1.
